hsync_line_gen: RTL and testbench

Horizontal timing generator for the 640x480 VGA path. Counts pixel-clock enables across an 800-clock line and walks a 4-state horizontal FSM (sync, back porch, active, front porch). Drives HSYNC and the pixel column. Maintains the 10-bit line counter LINE (0..524), which feeds the downstream vertical-sync FSM's line input and so determines the vertical state.

---
 rtl/hsync_line_gen.sv | 143 ++++++++++++++
 tb/tb_hsync_line_gen.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hsync_line_gen.sv
// hsync_line_gen
//
// Horizontal timing generator for the 640x480 VGA path. Counts pixel-clock
// enables across one line, tracks the horizontal phase (sync, back porch,
// active, front porch) and keeps the frame line counter that drives the
// downstream vertical-sync FSM.
//
// Ports:
//   CLK       in   1   system clock
//   RST       in   1   synchronous active-high reset (priority over CE)
//   CE        in   1   pixel-clock enable; all state advances only when high
//   HSYNC     out  1   0 during the sync pulse, 1 otherwise
//   HQ        out  2   horizontal phase: 0 sync, 1 back porch, 2 active, 3 front porch
//   HCNT      out 10   raw pixel counter, 0..H_TOTAL-1
//   X         out 10   active column (HCNT - (H_SYNC+H_BP)) while active, else 0
//   H_ACTIVE  out  1   high while HQ is the active phase
//   LINE      out 10   line counter, 0..V_TOTAL-1
//   LINE_END  out  1   single-CLK pulse on the cycle after each line wrap
//
// H_TOTAL and V_TOTAL must both be at most 1024 and every phase length
// must be non-zero.

module hsync_line_gen #(
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BP    = 48,
    parameter int unsigned H_ACT   = 640,
    parameter int unsigned H_FP    = 16,
    parameter int unsigned V_TOTAL = 525
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CE,
    output logic       HSYNC,
    output logic [1:0] HQ,
    output logic [9:0] HCNT,
    output logic [9:0] X,
    output logic       H_ACTIVE,
    output logic [9:0] LINE,
    output logic       LINE_END
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;

    // Pixel-counter values at which each phase begins, and the wrap points.
    localparam logic [9:0] BP_START  = 10'(H_SYNC);
    localparam logic [9:0] ACT_START = 10'(H_SYNC + H_BP);
    localparam logic [9:0] FP_START  = 10'(H_SYNC + H_BP + H_ACT);
    localparam logic [9:0] HCNT_MAX  = 10'(H_TOTAL - 1);
    localparam logic [9:0] LINE_MAX  = 10'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        StSync   = 2'd0,
        StBack   = 2'd1,
        StActive = 2'd2,
        StFront  = 2'd3
    } hstate_e;

    hstate_e    state_q, state_d;
    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] line_q, line_d;
    logic       line_end_q, line_end_d;
    logic       line_wrap;

    // ------------------------------------------------------------------
    // Pixel and line counters
    // ------------------------------------------------------------------

    // A qualifying edge at the last pixel of the line ends the line.
    assign line_wrap = CE && (hcnt_q == HCNT_MAX);

    always_comb begin
        hcnt_d     = hcnt_q;
        line_d     = line_q;
        line_end_d = line_wrap;
        if (CE) begin
            hcnt_d = (hcnt_q == HCNT_MAX) ? 10'd0 : hcnt_q + 10'd1;
        end
        if (line_wrap) begin
            line_d = (line_q == LINE_MAX) ? 10'd0 : line_q + 10'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hcnt_q     <= 10'd0;
            line_q     <= 10'd0;
            line_end_q <= 1'b0;
        end else begin
            hcnt_q     <= hcnt_d;
            line_q     <= line_d;
            line_end_q <= line_end_d;
        end
    end

    // ------------------------------------------------------------------
    // Horizontal phase FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StSync;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state. Decisions look at the counter value being loaded on this
    // edge, so the registered phase always agrees with the registered count.
    always_comb begin
        state_d = state_q;
        if (CE) begin
            case (state_q)
                StSync: begin
                    if (hcnt_d == BP_START) state_d = StBack;
                end
                StBack: begin
                    if (hcnt_d == ACT_START) state_d = StActive;
                end
                StActive: begin
                    if (hcnt_d == FP_START) state_d = StFront;
                end
                StFront: begin
                    if (hcnt_d == 10'd0) state_d = StSync;
                end
                default: state_d = StSync;
            endcase
        end
    end

    // Outputs: pure decodes of registered state, glitch-free w.r.t. inputs.
    always_comb begin
        HQ       = state_q;
        HSYNC    = (state_q != StSync);
        H_ACTIVE = (state_q == StActive);
        X        = (state_q == StActive) ? (hcnt_q - ACT_START) : 10'd0;
    end

    assign HCNT     = hcnt_q;
    assign LINE     = line_q;
    assign LINE_END = line_end_q;

endmodule

// File: tb/tb_hsync_line_gen.sv
module tb_hsync_line_gen;

    // Reduced-width horizontal timing for the second instance so that a
    // whole frame and a deep mid-frame reset fit in a short run.
    localparam int SS = 5;
    localparam int SB = 6;
    localparam int SA = 30;
    localparam int SF = 6;
    localparam int ST = SS + SB + SA + SF;  // 47

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic CE  = 1'b0;

    logic       HSYNC, H_ACTIVE, LINE_END;
    logic [1:0] HQ;
    logic [9:0] HCNT, X, LINE;
    logic       s_HSYNC, s_H_ACTIVE, s_LINE_END;
    logic [1:0] s_HQ;
    logic [9:0] s_HCNT, s_X, s_LINE;

    hsync_line_gen dut (
        .CLK      (CLK),
        .RST      (RST),
        .CE       (CE),
        .HSYNC    (HSYNC),
        .HQ       (HQ),
        .HCNT     (HCNT),
        .X        (X),
        .H_ACTIVE (H_ACTIVE),
        .LINE     (LINE),
        .LINE_END (LINE_END)
    );

    hsync_line_gen #(
        .H_SYNC  (SS),
        .H_BP    (SB),
        .H_ACT   (SA),
        .H_FP    (SF),
        .V_TOTAL (525)
    ) dut_s (
        .CLK      (CLK),
        .RST      (RST),
        .CE       (CE),
        .HSYNC    (s_HSYNC),
        .HQ       (s_HQ),
        .HCNT     (s_HCNT),
        .X        (s_X),
        .H_ACTIVE (s_H_ACTIVE),
        .LINE     (s_LINE),
        .LINE_END (s_LINE_END)
    );

    always #5 CLK = ~CLK;

    logic [34:0] b_obs, s_obs;
    assign b_obs = {HCNT, HQ, HSYNC, X, H_ACTIVE, LINE, LINE_END};
    assign s_obs = {s_HCNT, s_HQ, s_HSYNC, s_X, s_H_ACTIVE, s_LINE, s_LINE_END};

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: position within line/frame as plain integers.
    int mh, ml, mle;  // full-size instance
    int sh, sl, sle;  // reduced instance

    function automatic logic [34:0] model_vec(input int h, input int l, input int le,
                                              input int hs, input int hb, input int ha);
        int q;
        int x;
        logic hsy, act;
        if (h < hs)                q = 0;
        else if (h < hs + hb)      q = 1;
        else if (h < hs + hb + ha) q = 2;
        else                       q = 3;
        x   = (q == 2) ? h - hs - hb : 0;
        hsy = (q != 0);
        act = (q == 2);
        return {h[9:0], q[1:0], hsy, x[9:0], act, l[9:0], le[0]};
    endfunction

    // Apply inputs for one CLK edge, advance the model, sample 1ns later.
    task automatic step(input logic rst, input logic ce);
        RST = rst;
        CE  = ce;
        @(posedge CLK);
        if (rst) begin
            mh = 0; ml = 0; mle = 0;
            sh = 0; sl = 0; sle = 0;
        end else if (ce) begin
            mle = (mh == 799) ? 1 : 0;
            mh  = (mh + 1) % 800;
            if (mle != 0) ml = (ml + 1) % 525;
            sle = (sh == ST - 1) ? 1 : 0;
            sh  = (sh + 1) % ST;
            if (sle != 0) sl = (sl + 1) % 525;
        end else begin
            mle = 0;
            sle = 0;
        end
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1);
            n_chk++;
            if (b_obs !== model_vec(mh, ml, mle, 96, 48, 640)) begin
                n_fail++;
                $display("FAIL reset_full: actual %h expected %h", b_obs,
                         model_vec(mh, ml, mle, 96, 48, 640));
            end
            n_chk++;
            if (s_obs !== model_vec(sh, sl, sle, SS, SB, SA)) begin
                n_fail++;
                $display("FAIL reset_small: actual %h expected %h", s_obs,
                         model_vec(sh, sl, sle, SS, SB, SA));
            end
        end
    endtask

    task automatic test_one_line;
        int dur[4];
        int want[4];
        int low, act, le, x144, x783;
        want = '{96, 48, 640, 16};
        dur  = '{0, 0, 0, 0};
        low = 0; act = 0; le = 0; x144 = -1; x783 = -1;
        step(1'b1, 1'b1);
        for (int i = 0; i < 800; i++) begin
            step(1'b0, 1'b1);
            n_chk++;
            if (b_obs !== model_vec(mh, ml, mle, 96, 48, 640)) begin
                n_fail++;
                $display("FAIL line_cycle hcnt=%0d: actual %h expected %h", mh, b_obs,
                         model_vec(mh, ml, mle, 96, 48, 640));
            end
            dur[HQ]++;
            if (HSYNC === 1'b0)    low++;
            if (H_ACTIVE === 1'b1) act++;
            if (LINE_END === 1'b1) le++;
            if (HCNT == 10'd144) x144 = int'(X);
            if (HCNT == 10'd783) x783 = int'(X);
        end
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if (dur[k] != want[k]) begin
                n_fail++;
                $display("FAIL line_state%0d_len: actual %0d expected %0d", k, dur[k], want[k]);
            end
        end
        n_chk++;
        if (low != 96) begin
            n_fail++;
            $display("FAIL line_hsync_low: actual %0d expected 96", low);
        end
        n_chk++;
        if (act != 640) begin
            n_fail++;
            $display("FAIL line_active_len: actual %0d expected 640", act);
        end
        n_chk++;
        if (x144 != 0 || x783 != 639) begin
            n_fail++;
            $display("FAIL line_x_ends: actual %0d/%0d expected 0/639", x144, x783);
        end
        n_chk++;
        if (le != 1 || LINE !== 10'd1) begin
            n_fail++;
            $display("FAIL line_wrap: actual pulses=%0d line=%0d expected 1/1", le, LINE);
        end
        step(1'b0, 1'b1);
        n_chk++;
        if (LINE_END !== 1'b0 || HCNT !== 10'd1) begin
            n_fail++;
            $display("FAIL line_end_width: actual le=%b hcnt=%0d expected 0/1", LINE_END, HCNT);
        end
    endtask

    task automatic test_ce_toggle;
        int le;
        le = 0;
        step(1'b1, 1'b1);
        for (int i = 0; i < 1602; i++) begin
            step(1'b0, (i % 2 == 0) ? 1'b1 : 1'b0);
            n_chk++;
            if (b_obs !== model_vec(mh, ml, mle, 96, 48, 640)) begin
                n_fail++;
                $display("FAIL toggle_cycle i=%0d: actual %h expected %h", i, b_obs,
                         model_vec(mh, ml, mle, 96, 48, 640));
            end
            if (LINE_END === 1'b1) le++;
            if (i == 1598) begin
                n_chk++;
                if (LINE !== 10'd1 || HCNT !== 10'd0) begin
                    n_fail++;
                    $display("FAIL toggle_line_len: actual line=%0d hcnt=%0d expected 1/0",
                             LINE, HCNT);
                end
            end
        end
        n_chk++;
        if (le != 1) begin
            n_fail++;
            $display("FAIL toggle_line_end: actual %0d pulses expected 1", le);
        end
    endtask

    task automatic test_frame;
        int lv[4];
        int hold[4];
        int prev, wraps;
        lv   = '{1, 34, 514, 524};
        hold = '{0, 0, 0, 0};
        wraps = 0;
        step(1'b1, 1'b1);
        prev = int'(s_LINE);
        for (int i = 0; i < 525 * ST; i++) begin
            step(1'b0, 1'b1);
            n_chk++;
            if (s_obs !== model_vec(sh, sl, sle, SS, SB, SA)) begin
                n_fail++;
                $display("FAIL frame_cycle i=%0d: actual %h expected %h", i, s_obs,
                         model_vec(sh, sl, sle, SS, SB, SA));
            end
            for (int k = 0; k < 4; k++) if (int'(s_LINE) == lv[k]) hold[k]++;
            if (prev == 524 && int'(s_LINE) != 524) begin
                wraps++;
                n_chk++;
                if (s_HCNT !== 10'd0 || s_LINE !== 10'd0 || s_LINE_END !== 1'b1) begin
                    n_fail++;
                    $display("FAIL frame_wrap: actual hcnt=%0d line=%0d le=%b expected 0/0/1",
                             s_HCNT, s_LINE, s_LINE_END);
                end
            end
            prev = int'(s_LINE);
        end
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if (hold[k] != ST) begin
                n_fail++;
                $display("FAIL frame_hold_line%0d: actual %0d expected %0d", lv[k], hold[k], ST);
            end
        end
        n_chk++;
        if (wraps != 1) begin
            n_fail++;
            $display("FAIL frame_wrap_count: actual %0d expected 1", wraps);
        end
    endtask

    task automatic test_mid_reset;
        step(1'b1, 1'b1);
        // 14100 edges: full instance at pixel 500, reduced one at line 300.
        for (int i = 0; i < 14100; i++) step(1'b0, 1'b1);
        n_chk++;
        if (HCNT !== 10'd500 || s_LINE !== 10'd300) begin
            n_fail++;
            $display("FAIL midrst_position: actual hcnt=%0d sline=%0d expected 500/300",
                     HCNT, s_LINE);
        end
        step(1'b1, 1'b1);
        n_chk++;
        if (b_obs !== model_vec(mh, ml, mle, 96, 48, 640)) begin
            n_fail++;
            $display("FAIL midrst_full: actual %h expected %h", b_obs,
                     model_vec(mh, ml, mle, 96, 48, 640));
        end
        n_chk++;
        if (s_obs !== model_vec(sh, sl, sle, SS, SB, SA)) begin
            n_fail++;
            $display("FAIL midrst_small: actual %h expected %h", s_obs,
                     model_vec(sh, sl, sle, SS, SB, SA));
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1);
            n_chk++;
            if (b_obs !== model_vec(mh, ml, mle, 96, 48, 640)) begin
                n_fail++;
                $display("FAIL midrst_resume: actual %h expected %h", b_obs,
                         model_vec(mh, ml, mle, 96, 48, 640));
            end
        end
    endtask

    task automatic test_ce_hold;
        logic [9:0] h0;
        step(1'b1, 1'b1);
        for (int i = 0; i < 400; i++) step(1'b0, 1'b1);
        h0 = HCNT;
        for (int i = 0; i < 1000; i++) begin
            step(1'b0, 1'b0);
            n_chk++;
            if (b_obs !== model_vec(mh, ml, mle, 96, 48, 640)) begin
                n_fail++;
                $display("FAIL hold_cycle i=%0d: actual %h expected %h", i, b_obs,
                         model_vec(mh, ml, mle, 96, 48, 640));
            end
        end
        step(1'b0, 1'b1);
        n_chk++;
        if (HCNT !== 10'd401 || X !== 10'd257) begin
            n_fail++;
            $display("FAIL hold_resume: actual hcnt=%0d x=%0d (was %0d) expected 401/257",
                     HCNT, X, h0);
        end
    endtask

    task automatic test_random;
        logic r, c;
        step(1'b1, 1'b1);
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 599) == 0);
            c = ($urandom_range(0, 3) != 0);
            step(r, c);
            n_chk++;
            if (b_obs !== model_vec(mh, ml, mle, 96, 48, 640)) begin
                n_fail++;
                $display("FAIL random_full i=%0d: actual %h expected %h", i, b_obs,
                         model_vec(mh, ml, mle, 96, 48, 640));
            end
            n_chk++;
            if (s_obs !== model_vec(sh, sl, sle, SS, SB, SA)) begin
                n_fail++;
                $display("FAIL random_small i=%0d: actual %h expected %h", i, s_obs,
                         model_vec(sh, sl, sle, SS, SB, SA));
            end
        end
    endtask

    initial begin
        mh = 0; ml = 0; mle = 0;
        sh = 0; sl = 0; sle = 0;
        test_reset();
        test_one_line();
        test_ce_toggle();
        test_frame();
        test_mid_reset();
        test_ce_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
